// File: rtl/wb8_cmd_initiator_if.sv
// Command/response byte streams and wb8 initiator bus bundle.
// The master modport is the initiator's own view of these signals.
interface wb8_cmd_initiator_if;
  logic [7:0]  I_cmd_dat;
  logic        I_cmd_valid;
  logic        O_cmd_ready;
  logic [7:0]  O_rsp_dat;
  logic        O_rsp_valid;
  logic        I_rsp_ready;
  logic [31:0] O_wb_adr;
  logic [7:0]  O_wb_dat;
  logic [7:0]  I_wb_dat;
  logic        O_wb_cyc;
  logic        O_wb_stb;
  logic        O_wb_we;
  logic        I_wb_ack;
  logic        I_wb_stall;

  modport master (
    input  I_cmd_dat, I_cmd_valid,
    output O_cmd_ready,
    output O_rsp_dat, O_rsp_valid,
    input  I_rsp_ready,
    output O_wb_adr, O_wb_dat,
    output O_wb_cyc, O_wb_stb, O_wb_we,
    input  I_wb_dat, I_wb_ack, I_wb_stall
  );

  modport slave (
    output I_cmd_dat, I_cmd_valid,
    input  O_cmd_ready,
    input  O_rsp_dat, O_rsp_valid,
    output I_rsp_ready,
    input  O_wb_adr, O_wb_dat,
    input  O_wb_cyc, O_wb_stb, O_wb_we,
    output I_wb_dat, I_wb_ack, I_wb_stall
  );
endinterface

// File: rtl/wb8_cmd_initiator.sv
// Byte-stream driven wb8 bus initiator (debug/loader bridge).
// Decodes write/read command frames, runs one bus cycle, returns status.
module wb8_cmd_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  I_wb_clk,
  input  logic                  I_reset,
  wb8_cmd_initiator_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS_REQ,
    S_BUS_WAIT,
    S_RSP_STATUS,
    S_RSP_DATA
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  ST_OK    = 8'h00;
  localparam logic [7:0]  ST_TMO   = 8'hFF;
  localparam logic [7:0]  ST_BAD   = 8'hFE;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  wdat_q, wdat_d;
  logic        is_wr_q, is_wr_d;
  logic        is_rd_q, is_rd_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] wb_adr_q, wb_adr_d;
  logic [7:0]  wb_dat_q, wb_dat_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_dat_q, rsp_dat_d;

  logic cmd_xfer;
  logic rsp_xfer;
  logic start;
  logic done_ok;
  logic done_tmo;
  logic tmo_hit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    is_wr_d  = is_wr_q;
    is_rd_d  = is_rd_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    tmo_d    = tmo_q;
    wb_adr_d = wb_adr_q;
    wb_dat_d = wb_dat_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    start    = 1'b0;
    done_ok  = 1'b0;
    done_tmo = 1'b0;
    cmd_xfer = bus.I_cmd_valid && cmd_ready_q;
    rsp_xfer = rsp_valid_q && bus.I_rsp_ready;
    tmo_hit  = (tmo_q == TMO_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (cmd_xfer) begin
          is_wr_d = (bus.I_cmd_dat == 8'h01);
          is_rd_d = (bus.I_cmd_dat == 8'h02);
          if (bus.I_cmd_dat == 8'h01 ||
              bus.I_cmd_dat == 8'h02) begin
            cnt_d   = 2'd0;
            state_d = S_ADDR;
          end else begin
            status_d = ST_BAD;
            state_d  = S_RSP_STATUS;
          end
        end
      end
      S_ADDR: begin
        if (cmd_xfer) begin
          addr_d = {bus.I_cmd_dat, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (is_wr_q) state_d = S_DATA;
            else         start   = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (cmd_xfer) begin
          wdat_d = bus.I_cmd_dat;
          start  = 1'b1;
        end
      end
      S_BUS_REQ: begin
        tmo_d = tmo_q + 16'd1;
        // An ACK only counts in the cycle the request is accepted.
        if (!bus.I_wb_stall && bus.I_wb_ack) begin
          done_ok = 1'b1;
        end else if (tmo_hit) begin
          done_tmo = 1'b1;
        end else if (!bus.I_wb_stall) begin
          stb_d   = 1'b0;
          state_d = S_BUS_WAIT;
        end
      end
      S_BUS_WAIT: begin
        tmo_d = tmo_q + 16'd1;
        if (bus.I_wb_ack) done_ok  = 1'b1;
        else if (tmo_hit) done_tmo = 1'b1;
      end
      S_RSP_STATUS: begin
        if (rsp_xfer) begin
          if (is_rd_q &&
              (status_q == ST_OK || status_q == ST_TMO))
            state_d = S_RSP_DATA;
          else
            state_d = S_IDLE;
        end
      end
      S_RSP_DATA: begin
        if (rsp_xfer) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d  = S_BUS_REQ;
      tmo_d    = 16'd0;
      cyc_d    = 1'b1;
      stb_d    = 1'b1;
      we_d     = is_wr_q;
      wb_adr_d = addr_d;
      wb_dat_d = wdat_d;
    end

    if (done_ok || done_tmo) begin
      state_d  = S_RSP_STATUS;
      cyc_d    = 1'b0;
      stb_d    = 1'b0;
      we_d     = 1'b0;
      status_d = done_ok ? ST_OK : ST_TMO;
      rdata_d  = done_ok ? bus.I_wb_dat : 8'h00;
    end

    // Handshake outputs are registered from the next state.
    cmd_ready_d = (state_d == S_IDLE) ||
                  (state_d == S_ADDR) ||
                  (state_d == S_DATA);
    rsp_valid_d = (state_d == S_RSP_STATUS) ||
                  (state_d == S_RSP_DATA);
    rsp_dat_d   = rsp_dat_q;
    if (state_d == S_RSP_STATUS)    rsp_dat_d = status_d;
    else if (state_d == S_RSP_DATA) rsp_dat_d = rdata_d;
  end

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdat_q      <= '0;
      is_wr_q     <= 1'b0;
      is_rd_q     <= 1'b0;
      status_q    <= '0;
      rdata_q     <= '0;
      tmo_q       <= '0;
      wb_adr_q    <= '0;
      wb_dat_q    <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      is_wr_q     <= is_wr_d;
      is_rd_q     <= is_rd_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
      tmo_q       <= tmo_d;
      wb_adr_q    <= wb_adr_d;
      wb_dat_q    <= wb_dat_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  assign bus.O_cmd_ready = cmd_ready_q;
  assign bus.O_rsp_valid = rsp_valid_q;
  assign bus.O_rsp_dat   = rsp_dat_q;
  assign bus.O_wb_adr    = wb_adr_q;
  assign bus.O_wb_dat    = wb_dat_q;
  assign bus.O_wb_cyc    = cyc_q;
  assign bus.O_wb_stb    = stb_q;
  assign bus.O_wb_we     = we_q;

endmodule

// File: tb/tb_wb8_cmd_initiator.sv
// Randomized bench for wb8_cmd_initiator against a frame-level model.
// Responder timing is planned per command as (stall cycles, ack delay).
module tb_wb8_cmd_initiator;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb8_cmd_initiator_if bus();

  wb8_cmd_initiator #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .I_wb_clk (clk),
    .I_reset  (rst),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_rsp[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame-level reference: responses depend only on opcode and outcome.
  function automatic void model(input logic [7:0] op,
                                input bit ok,
                                input logic [7:0] rd);
    exp_rsp.delete();
    if (op != 8'h01 && op != 8'h02) begin
      exp_rsp.push_back(8'hFE);
    end else if (ok) begin
      exp_rsp.push_back(8'h00);
      if (op == 8'h02) exp_rsp.push_back(rd);
    end else begin
      exp_rsp.push_back(8'hFF);
      if (op == 8'h02) exp_rsp.push_back(8'h00);
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit x;
    int g = 0;
    bus.I_cmd_valid = 1'b1;
    bus.I_cmd_dat   = b;
    do begin
      x = bus.O_cmd_ready;
      @(negedge clk);
      g++;
    end while (!x && g < 100);
    bus.I_cmd_valid = 1'b0;
    if (!x) check("cmd_accept", 32'd0, 32'd1);
  endtask

  task automatic bus_phase(input int s, input int w,
                           input logic is_wr,
                           input logic [31:0] a,
                           input logic [7:0] d,
                           input logic [7:0] rd);
    int k = 0;
    int stb_n = 0;
    int cyc_n = 0;
    bit ok;
    int exp_stb;
    while (bus.O_wb_cyc && k < 200) begin
      if (bus.O_wb_stb) begin
        stb_n++;
        if (stb_n == 1) begin
          check("wb_adr", bus.O_wb_adr, a);
          check("wb_we", 32'(bus.O_wb_we), 32'(is_wr));
          if (is_wr) check("wb_dat", 32'(bus.O_wb_dat), 32'(d));
        end
      end
      cyc_n++;
      bus.I_wb_stall = (k < s);
      bus.I_wb_ack   = (w >= 0) && (k == s + w);
      bus.I_wb_dat   = bus.I_wb_ack ? rd : 8'($urandom);
      k++;
      @(negedge clk);
    end
    bus.I_wb_stall = 1'b0;
    bus.I_wb_ack   = 1'b0;
    ok      = (w >= 0) && (s + w <= TMO - 1);
    exp_stb = (s + 1 < TMO) ? s + 1 : TMO;
    check("stb_cycles", 32'(stb_n), 32'(exp_stb));
    check("cyc_cycles", 32'(cyc_n), ok ? 32'(s + w + 1) : 32'(TMO));
  endtask

  task automatic rsp_phase(input int hold);
    logic [7:0] got[$];
    int g = 0;
    bit v, r;
    bit pv = 1'b0;
    bit pr = 1'b0;
    logic [7:0] dd;
    logic [7:0] pd = 8'h00;
    while (got.size() < exp_rsp.size() && g < 300) begin
      v  = bus.O_rsp_valid;
      dd = bus.O_rsp_dat;
      check("no_cyc", 32'(bus.O_wb_cyc), 32'd0);
      if (v) check("cmd_ready_busy", 32'(bus.O_cmd_ready), 32'd0);
      if (v && pv && !pr) check("rsp_hold", 32'(dd), 32'(pd));
      r = (g >= hold) && ($urandom_range(3) != 0);
      bus.I_rsp_ready = r;
      bus.I_wb_ack    = 1'($urandom_range(1));
      bus.I_wb_stall  = 1'($urandom_range(1));
      pv = v;
      pr = r;
      pd = dd;
      g++;
      @(negedge clk);
      if (v && r) got.push_back(dd);
    end
    bus.I_rsp_ready = 1'b0;
    bus.I_wb_ack    = 1'b0;
    bus.I_wb_stall  = 1'b0;
    check("rsp_count", 32'(got.size()), 32'(exp_rsp.size()));
    foreach (got[i]) begin
      if (i < exp_rsp.size())
        check("rsp_byte", 32'(got[i]), 32'(exp_rsp[i]));
    end
    check("rsp_idle", 32'(bus.O_rsp_valid), 32'd0);
  endtask

  task automatic run_cmd(input logic [7:0] op,
                         input logic [31:0] a,
                         input logic [7:0] d,
                         input int s, input int w,
                         input logic [7:0] rd,
                         input int hold);
    bit ok;
    ok = (w >= 0) && (s + w <= TMO - 1);
    model(op, ok, rd);
    send_byte(op);
    if (op == 8'h01 || op == 8'h02) begin
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
      if (op == 8'h01) send_byte(d);
      bus_phase(s, w, op == 8'h01, a, d, rd);
    end
    rsp_phase(hold);
  endtask

  task automatic reset_mid_wait();
    logic [31:0] a;
    a = 32'hCAFE0010;
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    bus.I_wb_stall = 1'b0;
    bus.I_wb_ack   = 1'b0;
    @(negedge clk);
    check("rst_pre_cyc", 32'(bus.O_wb_cyc), 32'd1);
    check("rst_pre_stb", 32'(bus.O_wb_stb), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_cyc", 32'(bus.O_wb_cyc), 32'd0);
    check("rst_stb", 32'(bus.O_wb_stb), 32'd0);
    check("rst_rdy", 32'(bus.O_cmd_ready), 32'd0);
    rst = 1'b0;
    bus.I_rsp_ready = 1'b1;
    @(negedge clk);
    check("rst_rdy_back", 32'(bus.O_cmd_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("rst_no_rsp", 32'(bus.O_rsp_valid), 32'd0);
      @(negedge clk);
    end
    bus.I_rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  op;
    logic [7:0]  j;
    logic [31:0] a;
    int w;
    rst             = 1'b1;
    bus.I_cmd_dat   = 8'h00;
    bus.I_cmd_valid = 1'b0;
    bus.I_rsp_ready = 1'b0;
    bus.I_wb_dat    = 8'h00;
    bus.I_wb_ack    = 1'b0;
    bus.I_wb_stall  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.O_cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.O_rsp_valid), 32'd0);
    check("rst_cyc0", 32'(bus.O_wb_cyc), 32'd0);
    check("rst_stb0", 32'(bus.O_wb_stb), 32'd0);
    check("rst_we0", 32'(bus.O_wb_we), 32'd0);
    check("rst_adr0", bus.O_wb_adr, 32'd0);
    check("rst_dat0", 32'(bus.O_wb_dat), 32'd0);
    rst = 1'b0;

    run_cmd(8'h01, 32'h12345678, 8'hA5, 0, 0, 8'h00, 0);
    run_cmd(8'h02, 32'hFFFFF000, 8'h00, 3, 2, 8'h3C, 0);
    run_cmd(8'h02, 32'h00001000, 8'h00, 0, -1, 8'h00, 0);
    run_cmd(8'h7F, 32'h0, 8'h00, 0, 0, 8'h00, 0);
    run_cmd(8'h02, 32'h00000044, 8'h00, 1, 1, 8'h99, 0);
    run_cmd(8'h02, 32'h0BADF00D, 8'h00, 0, 1, 8'h5A, 5);
    run_cmd(8'h01, 32'h00000004, 8'h11, 3, 4, 8'h00, 0);
    run_cmd(8'h02, 32'h00000008, 8'h00, 4, 4, 8'h77, 0);
    run_cmd(8'h01, 32'h0000000C, 8'h22, 9, 0, 8'h00, 0);
    run_cmd(8'h02, 32'h00000010, 8'h00, 7, 0, 8'hC3, 0);
    reset_mid_wait();
    run_cmd(8'h01, 32'h87654321, 8'h5C, 0, 0, 8'h00, 0);

    for (int n = 0; n < 40; n++) begin
      j = 8'($urandom_range(9));
      if (j < 4)      op = 8'h01;
      else if (j < 8) op = 8'h02;
      else begin
        do op = 8'($urandom); while (op == 8'h01 || op == 8'h02);
      end
      a = $urandom;
      w = ($urandom_range(5) == 0) ? -1 : int'($urandom_range(5));
      run_cmd(op, a, 8'($urandom), int'($urandom_range(4)), w,
              8'($urandom), int'($urandom_range(3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
